// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one combinational integer ALU. It registers a
// response buffer per port and drains it with a valid/ready handshake.
module alu_share_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_op1_0,
  input  logic [31:0]      req_op1_1,
  input  logic [31:0]      req_op2_0,
  input  logic [31:0]      req_op2_1,
  input  logic [6:0]       req_opcode_0,
  input  logic [6:0]       req_opcode_1,
  input  logic [2:0]       req_funct3_0,
  input  logic [2:0]       req_funct3_1,
  input  logic [6:0]       req_funct7_0,
  input  logic [6:0]       req_funct7_1,
  input  logic [TAG_W-1:0] req_tag_0,
  input  logic [TAG_W-1:0] req_tag_1,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [6:0]       alu_opcode,
  output logic [2:0]       alu_funct3,
  output logic [6:0]       alu_funct7,
  input  logic [31:0]      alu_result,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_result_0,
  output logic [31:0]      rsp_result_1,
  output logic [TAG_W-1:0] rsp_tag_0,
  output logic [TAG_W-1:0] rsp_tag_1,
  output logic [15:0]      grant_cnt
);

  localparam int unsigned CNT_W = 16;

  logic [1:0] elig_c;
  logic [1:0] grant_c;
  logic       rr_ptr;

  // A port with a full buffer that is not draining this cycle cannot be granted.
  always_comb begin
    elig_c  = req_valid & ~(rsp_valid & ~rsp_ready);
    grant_c = 2'b00;
    case (elig_c)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11: begin
        if ((FIXED_PRIO != 0) || !rr_ptr) grant_c = 2'b01;
        else                              grant_c = 2'b10;
      end
      default: grant_c = 2'b00;
    endcase
    if (!rst_n) grant_c = 2'b00;
  end

  assign req_ready = grant_c;

  // The winner's fields drive the ALU. With no winner every field is 0,
  // so the ALU sees opcode 0.
  always_comb begin
    alu_op1    = '0;
    alu_op2    = '0;
    alu_opcode = '0;
    alu_funct3 = '0;
    alu_funct7 = '0;
    if (grant_c[0]) begin
      alu_op1    = req_op1_0;
      alu_op2    = req_op2_0;
      alu_opcode = req_opcode_0;
      alu_funct3 = req_funct3_0;
      alu_funct7 = req_funct7_0;
    end else if (grant_c[1]) begin
      alu_op1    = req_op1_1;
      alu_op2    = req_op2_1;
      alu_opcode = req_opcode_1;
      alu_funct3 = req_funct3_1;
      alu_funct7 = req_funct7_1;
    end
  end

  // Response buffers: a grant reloads the buffer, even when a drain happens in
  // the same cycle. A drain with no grant clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 2'b00;
      rsp_result_0 <= '0;
      rsp_result_1 <= '0;
      rsp_tag_0    <= '0;
      rsp_tag_1    <= '0;
    end else begin
      if (grant_c[0]) begin
        rsp_valid[0] <= 1'b1;
        rsp_result_0 <= alu_result;
        rsp_tag_0    <= req_tag_0;
      end else if (rsp_ready[0]) begin
        rsp_valid[0] <= 1'b0;
      end
      if (grant_c[1]) begin
        rsp_valid[1] <= 1'b1;
        rsp_result_1 <= alu_result;
        rsp_tag_1    <= req_tag_1;
      end else if (rsp_ready[1]) begin
        rsp_valid[1] <= 1'b0;
      end
    end
  end

  // After a grant the round-robin pointer moves to the other port.
  // Cycles without a grant leave it where it is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      grant_cnt <= '0;
    end else begin
      if (grant_c[0])      rr_ptr <= 1'b1;
      else if (grant_c[1]) rr_ptr <= 1'b0;
      if (|grant_c) grant_cnt <= grant_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational integer ALU (I-type opcode 7'b0010011 / R-type opcode 7'b0110011 decode, 32-bit result) between two requesters: port 0 = pipeline EX stage, port 1 = auxiliary requester (address-gen/debug).
- Per-port valid/ready request channel, one ALU grant per cycle, registered per-port response buffer with valid/ready drain, round-robin or fixed-priority arbitration.

Parameters:
- FIXED_PRIO, 0, 1 = port 0 always wins ties; 0 = round-robin.
- TAG_W, 4, width of requester tag returned with each result.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid, bit i = port i.
- req_ready  out  2  per-port request accepted this cycle (one-hot or zero).
- req_op1_0 / req_op1_1  in  32  operand 1 per port.
- req_op2_0 / req_op2_1  in  32  operand 2 per port.
- req_opcode_0 / req_opcode_1  in  7  opcode per port.
- req_funct3_0 / req_funct3_1  in  3  funct3 per port.
- req_funct7_0 / req_funct7_1  in  7  funct7 per port.
- req_tag_0 / req_tag_1  in  TAG_W  tag per port.
- alu_op1, alu_op2  out  32  operands driven to shared ALU.
- alu_opcode  out  7; alu_funct3  out  3; alu_funct7  out  7  controls to ALU.
- alu_result  in  32  combinational ALU result.
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response accept.
- rsp_result_0 / rsp_result_1  out  32  buffered result.
- rsp_tag_0 / rsp_tag_1  out  TAG_W  buffered tag.
- grant_cnt  out  16  total grants since reset, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async, rst_n low): rsp_valid=0, rsp_result_*=0, rsp_tag_*=0, grant_cnt=0, rr pointer=port 0 preferred. In-flight and buffered results discarded. req_ready is combinational and is 0 while rst_n is low.
- Eligibility: port i eligible when req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). Full buffer not being drained blocks the port.
- Arbitration (combinational, same cycle):
  - One eligible port: that port wins.
  - Both eligible: FIXED_PRIO=1 -> port 0. FIXED_PRIO=0 -> port indicated by rr pointer.
  - After any grant, rr pointer points to the other port. No grant leaves the pointer unchanged.
- req_ready = one-hot of winner, else 2'b00. A transfer occurs on req_valid[i] && req_ready[i].
- ALU drive: winner's op1/op2/opcode/funct3/funct7 are muxed to alu_* combinationally. With no winner, all alu_* are driven 0, so opcode 0 yields ALU result 0.
- Latency: alu_result is captured into the winner's buffer at the same rising edge as the transfer. rsp_valid[i] rises the next cycle. Fixed 1-cycle request-to-response latency.
- Response hold: rsp_result/rsp_tag stable while rsp_valid[i]=1 && rsp_ready[i]=0. Buffer clears (rsp_valid[i]->0) on handshake with no new grant to that port.
- Simultaneous drain + grant on same port: buffer reloads with new result, rsp_valid stays 1. Back-to-back throughput of 1 op/cycle per port when rsp_ready held high.
- Unsupported opcode/funct combos pass through untouched. The ALU returns 0, which is buffered and returned normally. No error flag.
- grant_cnt increments by 1 per transfer (max one per cycle).
- Requesters must hold request fields stable while req_valid=1 && req_ready=0. The block does not check this.
- Reset deasserted mid-stream: first grant occurs in the first cycle after release with rst_n high.

Test Plan:
- Single op: port 0 ADDI op1=5, op2=7, tag=3 -> req_ready=2'b01 same cycle. Next cycle rsp_valid[0]=1, rsp_result_0=12, rsp_tag_0=3. grant_cnt=1.
- Round-robin contention (FIXED_PRIO=0): both ports valid continuously, rsp_ready=2'b11 -> grants alternate 0,1,0,1. Port 1 SUB 10-3 returns 7. Port 0 SRAI 0x80000000>>>4 returns 0xF8000000.
- Fixed priority (FIXED_PRIO=1): both valid for 3 cycles -> port 0 granted all 3, port 1 req_ready=0 throughout.
- Backpressure: port 1 rsp_ready=0 after first result (SLTU 1<2 -> 1) -> next port 1 request not granted and rsp_result_1 stays 1. Raise rsp_ready -> grant in that same cycle, buffer reloads, rsp_valid[1] stays 1.
- Invalid op: opcode 7'b1111111 on port 0 -> accepted, rsp_result_0=0. R-type funct7=7'b0100000/funct3=3'b000 gives 10-3=7.
- Async reset mid-stream: rst_n low while rsp_valid=2'b11 -> rsp_valid=0, results/tags=0, grant_cnt=0 immediately, without waiting for a clock edge. After release, first grant goes to port 0 when both are valid.
